// File: rtl/video_readback_unpack.sv
// Display-side DDR readback: requests bursts, buffers words and unpacks them into RGB565 pixels
// aligned with vs_in/de_in. Define VIDEO_UNDERFLOW_MARK_EN to paint starved pixels magenta.
module video_readback_unpack #(
  parameter int         DQ_WIDTH     = 32,
  parameter int         VIDEO_WIDTH  = 1280,
  parameter int         VIDEO_HEIGHT = 720,
  parameter int         BURST_LEN    = 8,
  parameter int         BUF_DEPTH    = 16,
  parameter logic [3:0] IMAGE_TAG    = 4'd1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  vs_in,
  input  logic                  de_in,
  output logic                  rd_req,
  output logic [3:0]            rd_req_id,
  input  logic                  rd_ack,
  input  logic [DQ_WIDTH*8-1:0] ddr_data,
  input  logic                  ddr_data_valid,
  output logic                  frame_sync,
  output logic                  vs_out,
  output logic                  de_out,
  output logic [15:0]           rgb565_out,
  output logic [15:0]           underflow_cnt
);

  localparam int WORD_W       = DQ_WIDTH * 8;
  localparam int PIX_PER_WORD = WORD_W / 16;
  localparam int IW           = $clog2(PIX_PER_WORD);
  localparam int PW           = $clog2(BUF_DEPTH);
  localparam int CW           = $clog2(BUF_DEPTH + 1);
  localparam int BW           = $clog2(BURST_LEN + 1);
  localparam int FRAME_WORDS  = VIDEO_WIDTH * VIDEO_HEIGHT / PIX_PER_WORD;
  localparam int RW           = $clog2(FRAME_WORDS + BURST_LEN + 1);

  localparam logic [CW-1:0] SPACE_LVL   = CW'(BUF_DEPTH - BURST_LEN);
  localparam logic [CW-1:0] FULL_LVL    = CW'(BUF_DEPTH);
  localparam logic [BW-1:0] BURST_CNT   = BW'(BURST_LEN);
  localparam logic [BW-1:0] LAST_BEAT   = BW'(BURST_LEN - 1);
  localparam logic [RW-1:0] FRAME_CNT   = RW'(FRAME_WORDS);
  localparam logic [RW-1:0] BURST_WORDS = RW'(BURST_LEN);
  localparam logic [IW-1:0] LAST_IDX    = IW'(PIX_PER_WORD - 1);

`ifdef VIDEO_UNDERFLOW_MARK_EN
  localparam logic [15:0] UF_PIX = 16'hF81F;
`else
  localparam logic [15:0] UF_PIX = 16'h0000;
`endif

  typedef enum logic [1:0] {IDLE, REQ, DATA, DONE} state_t;

  state_t          state_q, state_d;
  logic            armed_q, armed_d;
  logic            rd_req_q, rd_req_d;
  logic [3:0]      rd_req_id_q, rd_req_id_d;
  logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
  logic [BW-1:0]   discard_q, discard_d;
  logic [RW-1:0]   req_words_q, req_words_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [IW-1:0]   pix_idx_q, pix_idx_d;
  logic [15:0]     uf_cnt_q, uf_cnt_d;
  logic            frame_sync_q, frame_sync_d;
  logic            vs_d1_q, vs_d1_d;
  logic            de_d1_q, de_d1_d;
  logic [15:0]     pix_s1_q, pix_s1_d;
  logic            vs_out_q, vs_out_d;
  logic            de_out_q, de_out_d;
  logic [15:0]     rgb_q, rgb_d;

  logic            vs_rise, buf_empty, accept, push, pop;
  logic [WORD_W-1:0] buf_mem [BUF_DEPTH];
  logic [WORD_W-1:0] head_word;
  logic [15:0]       head_pix [PIX_PER_WORD];

  assign head_word = buf_mem[rd_ptr_q];

  // Pixel k of a word lives in bits [16k+15:16k]
  for (genvar gi = 0; gi < PIX_PER_WORD; gi++) begin : g_pix
    assign head_pix[gi] = head_word[gi*16 +: 16];
  end

  always_ff @(posedge clk) begin
    if (push) buf_mem[wr_ptr_q] <= ddr_data;
  end

  always_comb begin
    vs_rise   = vs_in & ~vs_d1_q;
    buf_empty = (count_q == '0);
    accept    = (state_q == REQ) && rd_req_q && rd_ack;
    push      = (state_q == DATA) && ddr_data_valid && (count_q != FULL_LVL) && !vs_rise;
    pop       = de_in && !buf_empty && (pix_idx_q == LAST_IDX);

    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);

    state_d     = state_q;
    armed_d     = armed_q;
    beat_cnt_d  = beat_cnt_q;
    req_words_d = req_words_q;
    discard_d   = discard_q;
    if (discard_q != '0 && ddr_data_valid) discard_d = discard_q - BW'(1);

    case (state_q)
      IDLE: if (armed_q && count_q <= SPACE_LVL) state_d = REQ;
      REQ: begin
        if (accept) begin
          state_d     = DATA;
          beat_cnt_d  = '0;
          req_words_d = req_words_q + BURST_WORDS;
        end
      end
      DATA: begin
        if (ddr_data_valid) begin
          beat_cnt_d = beat_cnt_q + BW'(1);
          if (beat_cnt_q == LAST_BEAT) begin
            if (req_words_q == FRAME_CNT)  state_d = DONE;
            else if (count_d <= SPACE_LVL) state_d = REQ;
            else                           state_d = IDLE;
          end
        end
      end
      default: state_d = state_q;
    endcase

    pix_idx_d = pix_idx_q;
    uf_cnt_d  = uf_cnt_q;
    pix_s1_d  = 16'd0;
    if (de_in) begin
      if (buf_empty) begin
        pix_s1_d = UF_PIX;
        if (uf_cnt_q != 16'hFFFF) uf_cnt_d = uf_cnt_q + 16'd1;
      end else begin
        pix_s1_d  = head_pix[pix_idx_q];
        pix_idx_d = (pix_idx_q == LAST_IDX) ? '0 : pix_idx_q + IW'(1);
      end
    end

    // New frame: flush everything; beats still owed by the arbiter get swallowed
    if (vs_rise) begin
      state_d     = REQ;
      armed_d     = 1'b1;
      req_words_d = '0;
      beat_cnt_d  = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      pix_idx_d   = '0;
      uf_cnt_d    = 16'd0;
      if (state_q == DATA) discard_d = BURST_CNT - beat_cnt_q - BW'(ddr_data_valid);
      else if (accept)     discard_d = BURST_CNT;
    end

    rd_req_d     = (state_q == REQ) && (discard_q == '0) && !accept && !vs_rise;
    rd_req_id_d  = rd_req_d ? IMAGE_TAG : 4'd0;
    frame_sync_d = vs_rise;
    vs_d1_d      = vs_in;
    de_d1_d      = de_in;
    vs_out_d     = vs_d1_q;
    de_out_d     = de_d1_q;
    rgb_d        = de_d1_q ? pix_s1_q : 16'd0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      armed_q      <= 1'b0;
      rd_req_q     <= 1'b0;
      rd_req_id_q  <= 4'd0;
      beat_cnt_q   <= '0;
      discard_q    <= '0;
      req_words_q  <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      pix_idx_q    <= '0;
      uf_cnt_q     <= 16'd0;
      frame_sync_q <= 1'b0;
      vs_d1_q      <= 1'b0;
      de_d1_q      <= 1'b0;
      pix_s1_q     <= 16'd0;
      vs_out_q     <= 1'b0;
      de_out_q     <= 1'b0;
      rgb_q        <= 16'd0;
    end else begin
      state_q      <= state_d;
      armed_q      <= armed_d;
      rd_req_q     <= rd_req_d;
      rd_req_id_q  <= rd_req_id_d;
      beat_cnt_q   <= beat_cnt_d;
      discard_q    <= discard_d;
      req_words_q  <= req_words_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      pix_idx_q    <= pix_idx_d;
      uf_cnt_q     <= uf_cnt_d;
      frame_sync_q <= frame_sync_d;
      vs_d1_q      <= vs_d1_d;
      de_d1_q      <= de_d1_d;
      pix_s1_q     <= pix_s1_d;
      vs_out_q     <= vs_out_d;
      de_out_q     <= de_out_d;
      rgb_q        <= rgb_d;
    end
  end

  assign rd_req        = rd_req_q;
  assign rd_req_id     = rd_req_id_q;
  assign frame_sync    = frame_sync_q;
  assign vs_out        = vs_out_q;
  assign de_out        = de_out_q;
  assign rgb565_out    = rgb_q;
  assign underflow_cnt = uf_cnt_q;

endmodule

// File: tb/tb_video_readback_unpack.sv
// Directed bench for video_readback_unpack: cycle table for the first two bursts, then
// hand-written underflow, mid-burst frame restart, full small frame and async reset sequences.
module tb_video_readback_unpack;

  localparam int VW   = 128;
  localparam int VH   = 8;
  localparam int BL   = 8;
  localparam int LEAD = 64;
  localparam int LINE = 160;

`ifdef VIDEO_UNDERFLOW_MARK_EN
  localparam logic [15:0] UF_PIX = 16'hF81F;
`else
  localparam logic [15:0] UF_PIX = 16'h0000;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         vs_in = 1'b0, de_in = 1'b0, rd_ack = 1'b0, ddr_data_valid = 1'b0;
  logic [255:0] ddr_data = '0;
  logic         rd_req, frame_sync, vs_out, de_out;
  logic [3:0]   rd_req_id;
  logic [15:0]  rgb565_out, underflow_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int bn    = 0;

  typedef struct {
    logic vs, de, ack, dv;
    logic fs, req, vso, deo;
    logic [15:0] rgb;
  } vec_t;
  vec_t tbl [40];
  int   nv = 0;

  video_readback_unpack #(
    .DQ_WIDTH(32), .VIDEO_WIDTH(VW), .VIDEO_HEIGHT(VH),
    .BURST_LEN(BL), .BUF_DEPTH(16), .IMAGE_TAG(4'd1)
  ) dut (
    .clk(clk), .rst(rst), .vs_in(vs_in), .de_in(de_in),
    .rd_req(rd_req), .rd_req_id(rd_req_id), .rd_ack(rd_ack),
    .ddr_data(ddr_data), .ddr_data_valid(ddr_data_valid),
    .frame_sync(frame_sync), .vs_out(vs_out), .de_out(de_out),
    .rgb565_out(rgb565_out), .underflow_cnt(underflow_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Word j carries pixels j*16+1 .. j*16+16, pixel 0 in the low bits
  function automatic logic [255:0] word_of(input int j);
    logic [255:0] w;
    for (int k = 0; k < 16; k++) w[k*16 +: 16] = 16'(j*16 + k + 1);
    return w;
  endfunction

  function automatic logic [15:0] pix_of(input int j, input int k);
    return 16'(j*16 + k + 1);
  endfunction

  task automatic add(input logic vs, input logic de, input logic ack, input logic dv,
                     input logic fs, input logic req, input logic vso, input logic deo,
                     input logic [15:0] rgb);
    tbl[nv] = '{vs, de, ack, dv, fs, req, vso, deo, rgb};
    nv++;
  endtask

  task automatic beat(input int j);
    ddr_data_valid = 1'b1;
    ddr_data       = word_of(j);
    tick;
    ddr_data_valid = 1'b0;
    ddr_data       = '0;
  endtask

  initial begin
    int de_seen, bad, w, reqs, beats_left, wcnt, npix, pix_bad, req_hi;

    repeat (3) tick;
    check("reset_outputs", {rd_req, rd_req_id, frame_sync, vs_out, de_out, rgb565_out, underflow_cnt}, 64'd0);
    rst = 1'b1;
    tick;

    // expected outputs are those seen just after the edge that samples the row's inputs
    add(1,0,0,0, 1,0,0,0, 16'd0);
    add(1,0,0,0, 0,1,1,0, 16'd0);
    add(1,0,1,0, 0,0,1,0, 16'd0);
    add(0,0,0,1, 0,0,1,0, 16'd0);
    add(0,0,0,0, 0,0,0,0, 16'd0);
    for (int i = 0; i < 7; i++) add(0,0,0,1, 0,0,0,0, 16'd0);
    add(0,1,0,0, 0,1,0,0, 16'd0);
    add(0,1,0,0, 0,1,0,1, 16'd1);
    add(0,1,1,0, 0,0,0,1, 16'd2);
    for (int i = 0; i < 8; i++) add(0,1,0,1, 0,0,0,1, 16'(3 + i));
    for (int i = 0; i < 7; i++) add(0,1,0,0, 0,0,0,1, 16'(11 + i));
    add(0,0,0,0, 0,0,0,1, 16'd18);
    add(0,0,0,0, 0,0,0,0, 16'd0);

    for (int i = 0; i < nv; i++) begin
      vs_in          = tbl[i].vs;
      de_in          = tbl[i].de;
      rd_ack         = tbl[i].ack;
      ddr_data_valid = tbl[i].dv;
      ddr_data       = tbl[i].dv ? word_of(bn) : '0;
      if (tbl[i].dv) bn++;
      tick;
      check($sformatf("vec%0d", i),
            {frame_sync, rd_req, rd_req_id, vs_out, de_out, rgb565_out},
            {tbl[i].fs, tbl[i].req, (tbl[i].req ? 4'd1 : 4'd0), tbl[i].vso, tbl[i].deo, tbl[i].rgb});
    end
    vs_in = 0; de_in = 0; rd_ack = 0; ddr_data_valid = 0; ddr_data = '0;

    // Starvation: request outstanding, never acked, 20 pixels demanded
    vs_in = 1; tick; vs_in = 0; tick;
    check("uf_req_pending", {rd_req, rd_req_id}, {1'b1, 4'd1});
    de_seen = 0; bad = 0;
    for (int i = 0; i < 22; i++) begin
      de_in = (i < 20);
      tick;
      if (de_out) begin
        de_seen++;
        if (rgb565_out !== UF_PIX) bad++;
      end
    end
    de_in = 0;
    check("uf_count", underflow_cnt, 64'd20);
    check("uf_de_out_cycles", de_seen, 20);
    check("uf_pixel_bad", bad, 0);
    check("uf_req_still_held", rd_req, 1'b1);

    // Frame restart after beat 3: five beats discarded before a new request
    vs_in = 1; tick; vs_in = 0;
    check("uf_clear_on_vs", underflow_cnt, 64'd0);
    w = 0;
    while (!rd_req && w < 10) begin tick; w++; end
    check("disc_req_wait", rd_req, 1'b1);
    rd_ack = 1; tick; rd_ack = 0;
    for (int i = 0; i < 3; i++) beat(300 + i);
    vs_in = 1; tick; vs_in = 0;
    for (int i = 0; i < 5; i++) begin
      beat(400 + i);
      check($sformatf("disc_hold%0d", i), rd_req, 1'b0);
    end
    tick;
    check("disc_req_after", {rd_req, rd_req_id}, {1'b1, 4'd1});
    rd_ack = 1; tick; rd_ack = 0;
    for (int i = 0; i < 8; i++) beat(500 + i);
    de_in = 1; tick; de_in = 0; tick;
    check("disc_first_pix", {de_out, rgb565_out}, {1'b1, pix_of(500, 0)});

    // Whole (reduced-size) frame with a prompt arbiter
    vs_in = 1; tick; vs_in = 0;
    reqs = 0; beats_left = 0; wcnt = 0; npix = 0; pix_bad = 0;
    for (int c = 0; c < LEAD + VH*LINE + 300; c++) begin
      if (de_out) begin
        if (rgb565_out !== 16'(npix + 1)) pix_bad++;
        npix++;
      end
      ddr_data_valid = (beats_left > 0);
      ddr_data       = ddr_data_valid ? word_of(wcnt) : '0;
      if (ddr_data_valid) begin wcnt++; beats_left--; end
      if (rd_req && !rd_ack) begin
        rd_ack = 1; reqs++; beats_left = BL;
      end else begin
        rd_ack = 0;
      end
      de_in = (c >= LEAD) && ((c - LEAD) / LINE < VH) && ((c - LEAD) % LINE < VW);
      tick;
    end
    de_in = 0; rd_ack = 0; ddr_data_valid = 0; ddr_data = '0;
    check("frame_requests", reqs, VW*VH/16/BL);
    check("frame_pixels", npix, VW*VH);
    check("frame_pixel_bad", pix_bad, 0);
    check("frame_underflow", underflow_cnt, 64'd0);

    // Reset dropped in the middle of a burst
    vs_in = 1; de_in = 1; tick; vs_in = 0; tick;
    check("rst_pre_req", rd_req, 1'b1);
    rd_ack = 1; tick; rd_ack = 0; de_in = 0;
    for (int i = 0; i < 3; i++) beat(700 + i);
    de_in = 1;
    repeat (3) tick;
    check("rst_pre_state", {de_out, rgb565_out, underflow_cnt}, {1'b1, pix_of(700, 1), 16'd2});
    de_in = 0;
    #2 rst = 1'b0;
    #1;
    check("rst_async_clear", {rd_req, rd_req_id, frame_sync, vs_out, de_out, rgb565_out, underflow_cnt}, 64'd0);
    tick;
    rst = 1'b1;
    req_hi = 0;
    for (int i = 0; i < 5; i++) begin
      beat(800 + i);
      if (rd_req || frame_sync) req_hi++;
    end
    for (int i = 0; i < 20; i++) begin
      tick;
      if (rd_req || frame_sync) req_hi++;
    end
    check("rst_no_req", req_hi, 0);
    vs_in = 1; tick; vs_in = 0;
    check("rst_vs_sync", frame_sync, 1'b1);
    tick;
    check("rst_req_after_vs", {rd_req, rd_req_id}, {1'b1, 4'd1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
